// File: rtl/fil_spad_rx_pkg.sv
// Shared constants, FSM state type and config-size helper for the PE filter scratchpad receiver.
package fil_spad_rx_pkg;
  localparam int FIL_DATA_W     = 16;
  localparam int PE_ROWS        = 12;
  localparam int FIL_SPAD_DEPTH = 224;
  localparam int FIL_SPAD_AW    = 8;
  localparam int CFG_W          = 5;
  localparam int PROD_W         = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } fsm_state_t;

  // 31*31*31 fits in PROD_W bits, so no product bits are lost.
  function automatic logic [PROD_W-1:0] cfg_total(input logic [CFG_W-1:0] a,
                                                  input logic [CFG_W-1:0] b,
                                                  input logic [CFG_W-1:0] c);
    return PROD_W'(a) * PROD_W'(b) * PROD_W'(c);
  endfunction
endpackage

// File: rtl/fil_spad_rx_if.sv
// MAC-side read port of the filter scratchpad: request with (oc, ic, col) index, registered reply.
interface fil_spad_rx_if
  import fil_spad_rx_pkg::*;
#(
  parameter int DATA_W = FIL_DATA_W
);
  logic              rd_req;
  logic [CFG_W-1:0]  rd_oc;
  logic [CFG_W-1:0]  rd_ic;
  logic [CFG_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  modport master (output rd_req, rd_oc, rd_ic, rd_col,
                  input  rd_data, rd_valid, rd_err);
  modport slave  (input  rd_req, rd_oc, rd_ic, rd_col,
                  output rd_data, rd_valid, rd_err);
endinterface

// File: rtl/fil_spad_rx_mem.sv
// 1W1R scratchpad RAM; read data is registered and holds its value when no read is issued.
module fil_spad_rx_mem
  import fil_spad_rx_pkg::*;
#(
  parameter int DATA_W = FIL_DATA_W,
  parameter int DEPTH  = FIL_SPAD_DEPTH,
  parameter int ADDR_W = FIL_SPAD_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fil_spad_rx.sv
// PE-side filter row-wire receiver: captures a load window into the scratchpad and serves MAC reads.
// Words are captured one cycle after the enable is sampled, matching the filter bank's output register.
module fil_spad_rx
  import fil_spad_rx_pkg::*;
#(
  parameter int DATA_W = FIL_DATA_W,
  parameter int DEPTH  = FIL_SPAD_DEPTH,
  parameter int ADDR_W = FIL_SPAD_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CFG_W-1:0]  oc,
  input  logic [CFG_W-1:0]  ic,
  input  logic [CFG_W-1:0]  filter_width,
  input  logic [DATA_W-1:0] w_in,
  fil_spad_rx_if.slave      rd,
  output logic              ready,
  output logic              load_done,
  output logic              load_abort,
  output logic              cfg_err
);
  fsm_state_t        state, state_nxt;
  logic              en_d;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [CFG_W-1:0]  oc_l, ic_l, fw_l;
  logic [PROD_W-1:0] total_l, total_new;
  logic              ready_nxt, cfg_err_nxt, done_nxt, abort_nxt;
  logic              rise, cfg_ok, cap, last;
  logic              rd_ok, rd_hit;
  logic [ADDR_W-1:0] rd_addr;

  assign rise      = en & ~en_d;
  assign total_new = cfg_total(oc, ic, filter_width);
  assign cfg_ok    = (total_new != '0) && (total_new <= PROD_W'(DEPTH));
  assign cap       = (state == LOAD) && en_d;
  assign last      = cap && ((PROD_W'(wr_ptr) + PROD_W'(1)) == total_l);

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    ready_nxt   = ready;
    cfg_err_nxt = cfg_err;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    unique case (state)
      IDLE:  ;
      LOAD: begin
        if (!en_d) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else begin
          wr_ptr_nxt = wr_ptr + ADDR_W'(1);
          if (last) begin
            state_nxt = READY;
            done_nxt  = 1'b1;
            ready_nxt = 1'b1;
          end
        end
      end
      READY: ;
      default: state_nxt = IDLE;
    endcase
    // A new window always restarts from the top, whatever was in progress.
    if (rise) begin
      ready_nxt   = 1'b0;
      wr_ptr_nxt  = '0;
      cfg_err_nxt = ~cfg_ok;
      state_nxt   = cfg_ok ? LOAD : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      en_d       <= 1'b0;
      wr_ptr     <= '0;
      ready      <= 1'b0;
      cfg_err    <= 1'b0;
      load_done  <= 1'b0;
      load_abort <= 1'b0;
      oc_l       <= '0;
      ic_l       <= '0;
      fw_l       <= '0;
      total_l    <= '0;
    end else begin
      state      <= state_nxt;
      en_d       <= en;
      wr_ptr     <= wr_ptr_nxt;
      ready      <= ready_nxt;
      cfg_err    <= cfg_err_nxt;
      load_done  <= done_nxt;
      load_abort <= abort_nxt;
      if (rise) begin
        oc_l    <= oc;
        ic_l    <= ic;
        fw_l    <= filter_width;
        total_l <= total_new;
      end
    end
  end

  // Reads use the config of the current filter set, so a read on a reload edge still sees the old shape.
  assign rd_ok   = (state == READY) && (rd.rd_oc < oc_l) && (rd.rd_ic < ic_l) && (rd.rd_col < fw_l);
  assign rd_hit  = rd.rd_req && rd_ok;
  assign rd_addr = ADDR_W'((PROD_W'(rd.rd_col) * PROD_W'(ic_l) + PROD_W'(rd.rd_ic)) * PROD_W'(oc_l)
                           + PROD_W'(rd.rd_oc));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_err   <= 1'b0;
    end else begin
      rd.rd_valid <= rd_hit;
      rd.rd_err   <= rd.rd_req && !rd_ok;
    end
  end

  fil_spad_rx_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap),
    .wr_addr (wr_ptr),
    .wr_data (w_in),
    .rd_en   (rd_hit),
    .rd_addr (rd_addr),
    .rd_data (rd.rd_data)
  );
endmodule

// File: tb/tb_fil_spad_rx.sv
// Directed bench for fil_spad_rx: transaction-level model plus literal spot checks.
module tb_fil_spad_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  oc = '0, ic = '0, filter_width = '0;
  logic [15:0] w_in = '0;
  logic        ready, load_done, load_abort, cfg_err;

  fil_spad_rx_if #(.DATA_W(16)) rdif ();

  fil_spad_rx dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .oc           (oc),
    .ic           (ic),
    .filter_width (filter_width),
    .w_in         (w_in),
    .rd           (rdif),
    .ready        (ready),
    .load_done    (load_done),
    .load_abort   (load_abort),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_abort = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model phases: 0 no filter set / idle, 1 loading, 2 complete set held.
  int          m_ph = 0;
  int          m_oc = 0, m_ic = 0, m_fw = 0, m_total = 0;
  bit          m_en_prev = 1'b0;
  logic [15:0] m_words[$];
  logic [15:0] m_img[256];
  logic [15:0] m_data = '0;
  bit          m_valid = 0, m_err = 0, m_ready = 0, m_done = 0, m_abort = 0, m_cfg_err = 0;

  task automatic model_step();
    int a;
    if (rst) begin
      m_ph = 0; m_en_prev = 0; m_data = '0; m_valid = 0; m_err = 0;
      m_ready = 0; m_done = 0; m_abort = 0; m_cfg_err = 0;
      m_oc = 0; m_ic = 0; m_fw = 0; m_total = 0;
      m_words.delete();
      return;
    end
    m_valid = 0; m_err = 0;
    if (rdif.rd_req) begin
      if (m_ph == 2 && rdif.rd_oc < m_oc && rdif.rd_ic < m_ic && rdif.rd_col < m_fw) begin
        a = (int'(rdif.rd_col) * m_ic + int'(rdif.rd_ic)) * m_oc + int'(rdif.rd_oc);
        m_data = m_img[a];
        m_valid = 1;
      end else begin
        m_err = 1;
      end
    end
    m_done = 0; m_abort = 0;
    if (m_ph == 1) begin
      if (m_en_prev) begin
        m_words.push_back(w_in);
        if (m_words.size() == m_total) begin
          foreach (m_words[i]) m_img[i] = m_words[i];
          m_ph = 2; m_ready = 1; m_done = 1;
        end
      end else begin
        m_ph = 0; m_abort = 1;
      end
    end
    if (en && !m_en_prev) begin
      m_oc = int'(oc); m_ic = int'(ic); m_fw = int'(filter_width);
      m_total = m_oc * m_ic * m_fw;
      m_ready = 0;
      m_words.delete();
      if (m_total == 0 || m_total > 224) begin
        m_cfg_err = 1; m_ph = 0;
      end else begin
        m_cfg_err = 0; m_ph = 1;
      end
    end
    m_en_prev = en;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (load_done === 1'b1) n_done++;
    if (load_abort === 1'b1) n_abort++;
    if (chk_on) begin
      chk("rd_valid", {31'b0, rdif.rd_valid}, {31'b0, m_valid});
      chk("rd_err", {31'b0, rdif.rd_err}, {31'b0, m_err});
      chk("rd_data", {16'b0, rdif.rd_data}, {16'b0, m_data});
      chk("ready", {31'b0, ready}, {31'b0, m_ready});
      chk("load_done", {31'b0, load_done}, {31'b0, m_done});
      chk("load_abort", {31'b0, load_abort}, {31'b0, m_abort});
      chk("cfg_err", {31'b0, cfg_err}, {31'b0, m_cfg_err});
    end
  end

  task automatic load(input logic [4:0] t_oc, input logic [4:0] t_ic, input logic [4:0] t_fw,
                      input logic [15:0] base, input int n, input bit rd_rise);
    @(negedge clk);
    oc = t_oc; ic = t_ic; filter_width = t_fw; en = 1'b1;
    if (rd_rise) begin
      rdif.rd_req = 1'b1; rdif.rd_oc = 5'd1; rdif.rd_ic = 5'd1; rdif.rd_col = 5'd2;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w_in = base + 16'(k);
      en = (k < n - 1);
      if (rd_rise && k == 0) begin
        rdif.rd_req = 1'b0;
        chk("rise_rd_valid", {31'b0, rdif.rd_valid}, 32'd1);
        chk("rise_rd_data", {16'b0, rdif.rd_data}, 32'h10B);
        chk("rise_ready_drop", {31'b0, ready}, 32'd0);
      end
    end
    @(negedge clk);
    w_in = '0;
  endtask

  task automatic rd(input logic [4:0] r_oc, input logic [4:0] r_ic, input logic [4:0] r_col);
    @(negedge clk);
    rdif.rd_req = 1'b1; rdif.rd_oc = r_oc; rdif.rd_ic = r_ic; rdif.rd_col = r_col;
    @(negedge clk);
    rdif.rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rdif.rd_req = 1'b0; rdif.rd_oc = '0; rdif.rd_ic = '0; rdif.rd_col = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("reset_rd_valid", {31'b0, rdif.rd_valid}, 32'd0);
    chk("reset_rd_data", {16'b0, rdif.rd_data}, 32'd0);
    rst = 1'b0;

    // 1: full load of 12 words, then read (oc1, ic0, col2) -> address 9
    load(5'd2, 5'd2, 5'd3, 16'h100, 12, 1'b0);
    chk("t1_ready", {31'b0, ready}, 32'd1);
    chk("t1_done_count", n_done, 32'd1);
    rd(5'd1, 5'd0, 5'd2);
    chk("t1_rd_valid", {31'b0, rdif.rd_valid}, 32'd1);
    chk("t1_rd_data", {16'b0, rdif.rd_data}, 32'h109);

    // 2: window closes after 7 words
    load(5'd2, 5'd2, 5'd3, 16'h300, 7, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_abort_count", n_abort, 32'd1);
    chk("t2_ready", {31'b0, ready}, 32'd0);
    rd(5'd0, 5'd0, 5'd0);
    chk("t2_rd_err", {31'b0, rdif.rd_err}, 32'd1);
    chk("t2_rd_valid", {31'b0, rdif.rd_valid}, 32'd0);
    chk("t2_rd_data_hold", {16'b0, rdif.rd_data}, 32'h109);

    // 3: oversize config 8*8*4 = 256
    load(5'd8, 5'd8, 5'd4, 16'h400, 4, 1'b0);
    chk("t3_cfg_err", {31'b0, cfg_err}, 32'd1);
    chk("t3_ready", {31'b0, ready}, 32'd0);
    rd(5'd0, 5'd0, 5'd0);
    chk("t3_rd_err", {31'b0, rdif.rd_err}, 32'd1);
    load(5'd2, 5'd2, 5'd3, 16'h100, 12, 1'b0);
    chk("t3_cfg_err_clear", {31'b0, cfg_err}, 32'd0);
    chk("t3_ready_again", {31'b0, ready}, 32'd1);

    // 4: reload from READY with a read on the enable edge; two trailing words must be ignored
    load(5'd1, 5'd1, 5'd3, 16'h0A0, 5, 1'b1);
    chk("t4_ready", {31'b0, ready}, 32'd1);
    rd(5'd0, 5'd0, 5'd1);
    chk("t4_rd_data_a1", {16'b0, rdif.rd_data}, 32'hA1);
    rd(5'd0, 5'd0, 5'd2);
    chk("t4_rd_data_a2", {16'b0, rdif.rd_data}, 32'hA2);

    // 5: out-of-range column and filter index
    rd(5'd0, 5'd0, 5'd3);
    chk("t5_rd_err", {31'b0, rdif.rd_err}, 32'd1);
    chk("t5_rd_data_hold", {16'b0, rdif.rd_data}, 32'hA2);
    rd(5'd1, 5'd0, 5'd0);
    chk("t5_rd_err_oc", {31'b0, rdif.rd_err}, 32'd1);

    // 6: reset lands on the 5th word of a load
    @(negedge clk);
    oc = 5'd2; ic = 5'd2; filter_width = 5'd3; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      w_in = 16'h500 + 16'(k);
      if (k == 4) begin
        rst = 1'b1; en = 1'b0;
      end
    end
    @(negedge clk);
    chk("t6_ready", {31'b0, ready}, 32'd0);
    chk("t6_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("t6_load_done", {31'b0, load_done}, 32'd0);
    chk("t6_load_abort", {31'b0, load_abort}, 32'd0);
    chk("t6_rd_valid", {31'b0, rdif.rd_valid}, 32'd0);
    chk("t6_rd_data", {16'b0, rdif.rd_data}, 32'd0);
    rst = 1'b0;
    load(5'd2, 5'd2, 5'd3, 16'h200, 12, 1'b0);
    chk("t6_reload_ready", {31'b0, ready}, 32'd1);
    rd(5'd1, 5'd1, 5'd2);
    chk("t6_rd_data", {16'b0, rdif.rd_data}, 32'h20B);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
